demux_1x32_sweep: RTL and testbench
===================================

DEMUX_1X32_SWEEP -- requirements
Module: demux_1x32_sweep

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 1, giving the dwell clocks per bit during a sweep (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port din, input, 1 bit: serial data bit, e.g. the out of the companion 32x1 mux.
REQ-005 SHALL have port sel, input, 5 bits: bit index for manual writes.
REQ-006 SHALL have port wr_en, input, 1 bit: manual write strobe.
REQ-007 SHALL have port start, input, 1 bit: request an automatic 32-bit sweep.
REQ-008 SHALL have port sel_cur, output, 5 bits: current sweep index, intended to drive the companion mux sel.
REQ-009 SHALL have port out, output, 32 bits: registered demultiplexed word.
REQ-010 SHALL have port busy, output, 1 bit: high while in SWEEP.
REQ-011 SHALL have port out_valid, output, 1 bit: word complete, held until accepted.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts word when out_valid && out_ready.

Function
REQ-013 SHALL implement states IDLE, SWEEP, HOLD; reset state IDLE.
REQ-014 In IDLE with wr_en=1 and start=0, SHALL set out[sel] <= din on the edge, all other bits unchanged.
REQ-015 In IDLE with start=1, SHALL enter SWEEP, clear out to 0, set sel_cur=0 and the dwell counter to 0; a coincident wr_en is dropped.
REQ-016 In SWEEP, SHALL sample din into out[sel_cur] on the edge where the dwell counter equals BIT_CYCLES-1, then reset the dwell counter and increment sel_cur.
REQ-017 When bit 31 is sampled, SHALL enter HOLD with out_valid=1 and busy=0; sel_cur then reads 0, without wrapping further.
REQ-018 Latency: out_valid SHALL rise exactly 32*BIT_CYCLES clocks after the edge that sampled start.
REQ-019 In HOLD, out and out_valid SHALL be stable until out_valid && out_ready; on that edge the block returns to IDLE with out_valid=0 and out retained.
REQ-020 SHALL ignore start in SWEEP and HOLD, ignore wr_en in SWEEP and HOLD, and ignore out_ready outside HOLD.
REQ-021 sel_cur SHALL equal 0 in IDLE and HOLD.

Reset
REQ-022 On rst=1 at an edge, SHALL force state IDLE, out=0, sel_cur=0, dwell counter 0, busy=0, out_valid=0 (and parity=0 when present), regardless of state; an in-progress sweep is discarded.
REQ-023 rst SHALL take priority over start, wr_en and out_ready in the same cycle.

Configuration
REQ-024 With macro DEMUX_SWEEP_PARITY_EN defined, SHALL add output parity (1 bit) equal to the XOR of all 32 bits of out, registered so it is valid with out_valid and updated by manual writes; without the macro, the port and logic SHALL be absent and all other behaviour identical.

Structure
REQ-025 Package demux_pkg SHALL hold the state enum (IDLE/SWEEP/HOLD), WORD_W=32, SEL_W=5.
REQ-026 The dwell counter SHALL be a sub-module demux_dwell_cnt (clear, enable, terminal-count output at BIT_CYCLES-1).

Verification
REQ-027 Loop-back: companion mux with in=32'h55555555, sel driven by sel_cur, din=mux out, BIT_CYCLES=1, pulse start -> out_valid after 32 clocks, out=32'h55555555, busy high for 32 clocks.
REQ-028 BIT_CYCLES=10, same loop-back with in=32'hDEADBEEF -> out_valid after 320 clocks, out=32'hDEADBEEF, sel_cur steps every 10 clocks.
REQ-029 Backpressure: out_ready=0 for 5 clocks after out_valid -> out and out_valid held; start pulsed during HOLD is ignored; out_ready=1 -> IDLE next edge.
REQ-030 Manual: from reset, wr_en with sel=31 and din=1, then sel=0 and din=1 -> out=32'h80000001; start+wr_en together -> write dropped, out cleared.
REQ-031 Reset mid-sweep: rst at sweep bit 17 -> next edge all outputs 0, IDLE; a new start then completes normally.
REQ-032 With DEMUX_SWEEP_PARITY_EN: sweep 32'h00000007 -> parity=1; sweep 32'h00000003 -> parity=0.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding and widths for the 1x32 sweep demux
package demux_pkg;
  localparam int WORD_W = 32;
  localparam int SEL_W  = 5;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/demux_dwell_cnt.sv
// rtl/demux_dwell_cnt.sv - per-bit dwell counter, o_tc high on count BIT_CYCLES-1
module demux_dwell_cnt #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam logic [7:0] TC_VAL = 8'(BIT_CYCLES - 1);

  logic [7:0] r_cnt;

  assign o_tc = (r_cnt == TC_VAL);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= o_tc ? 8'd0 : r_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/demux_1x32_sweep.sv
// rtl/demux_1x32_sweep.sv - serial-to-parallel sweep demux with manual bit writes
// Optional parity output enabled by DEMUX_SWEEP_PARITY_EN.
module demux_1x32_sweep
  import demux_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic [SEL_W-1:0]  sel,
  input  logic              wr_en,
  input  logic              start,
  output logic [SEL_W-1:0]  sel_cur,
  output logic [WORD_W-1:0] out,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready
`ifdef DEMUX_SWEEP_PARITY_EN
  ,
  output logic              parity
`endif
);
  state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_out, w_out_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic              w_tc, w_cnt_en, w_cnt_clr;

  demux_dwell_cnt #(.BIT_CYCLES(BIT_CYCLES)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Counter is held clear outside SWEEP, so entry always starts a fresh dwell.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_sel_nxt   = r_sel;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SWEEP;
          w_out_nxt   = '0;
          w_sel_nxt   = '0;
        end else if (wr_en) begin
          w_out_nxt[sel] = din;
        end
      end
      SWEEP: begin
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b1;
        if (w_tc) begin
          w_out_nxt[r_sel] = din;
          if (r_sel == LAST_SEL) begin
            w_state_nxt = HOLD;
            w_sel_nxt   = '0;
          end else begin
            w_sel_nxt = r_sel + 5'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out       = r_out;
  assign sel_cur   = r_sel;
  assign busy      = (r_state == SWEEP);
  assign out_valid = (r_state == HOLD);

`ifdef DEMUX_SWEEP_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ^w_out_nxt;
  end

  assign parity = r_parity;
`endif
endmodule

// File: tb/tb_demux_1x32_sweep.sv
// tb/tb_demux_1x32_sweep.sv - self-checking bench, BIT_CYCLES=1 and BIT_CYCLES=10 instances
module tb_demux_1x32_sweep;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, wr_en = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic        man_din = 1'b0, loopback = 1'b0, cur = 1'b0;
  logic [4:0]  sel = '0;
  logic [31:0] mux_in = '0;

  logic [4:0]  sel_a, sel_b;
  logic [31:0] out_a, out_b;
  logic        busy_a, busy_b, val_a, val_b, din_a, din_b;
  logic        start_a, start_b, rdy_a, rdy_b;
  logic        par_a, par_b;

  assign din_a   = loopback ? mux_in[sel_a] : man_din;
  assign din_b   = loopback ? mux_in[sel_b] : man_din;
  assign start_a = start & ~cur;
  assign start_b = start & cur;
  assign rdy_a   = out_ready & ~cur;
  assign rdy_b   = out_ready & cur;

  demux_1x32_sweep #(.BIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .sel(sel), .wr_en(wr_en), .start(start_a),
    .sel_cur(sel_a), .out(out_a), .busy(busy_a), .out_valid(val_a), .out_ready(rdy_a)
`ifdef DEMUX_SWEEP_PARITY_EN
    , .parity(par_a)
`endif
  );

  demux_1x32_sweep #(.BIT_CYCLES(10)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .sel(sel), .wr_en(wr_en), .start(start_b),
    .sel_cur(sel_b), .out(out_b), .busy(busy_b), .out_valid(val_b), .out_ready(rdy_b)
`ifdef DEMUX_SWEEP_PARITY_EN
    , .parity(par_b)
`endif
  );

`ifndef DEMUX_SWEEP_PARITY_EN
  assign par_a = 1'b0;
  assign par_b = 1'b0;
`endif

  logic [31:0] m_out;
  logic [4:0]  m_sel;
  logic        m_busy, m_valid, m_par;
  assign m_out   = cur ? out_b  : out_a;
  assign m_sel   = cur ? sel_b  : sel_a;
  assign m_busy  = cur ? busy_b : busy_a;
  assign m_valid = cur ? val_b  : val_a;
  assign m_par   = cur ? par_b  : par_a;

  typedef struct { logic [31:0] word; int lat; } exp_t;
  typedef struct { logic c; logic [31:0] word; } vec_t;
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input logic c, input logic [31:0] w, input bit accept);
    int   bc, lat, busy_n, step_bad;
    exp_t e;
    bc       = c ? 10 : 1;
    cur      = c;
    loopback = 1'b1;
    mux_in   = w;
    start    = 1'b1;
    sb.push_back('{w, 32 * bc});
    tick();
    start = 1'b0;
    check("sweep_clear", m_out, 32'h0);
    lat = 0; busy_n = 0; step_bad = 0;
    while (!m_valid && lat < 32 * bc + 20) begin
      if (m_busy) busy_n++;
      if (lat < 32 * bc && m_sel != 5'(lat / bc)) step_bad++;
      tick();
      lat++;
    end
    check("valid_seen", {31'b0, m_valid}, 32'h1);
    e = sb.pop_front();
    check("word", m_out, e.word);
    check("latency", lat, e.lat);
    check("busy_cycles", busy_n, e.lat);
    check("sel_step", step_bad, 0);
    check("hold_sel", {27'b0, m_sel}, 32'h0);
    check("hold_busy", {31'b0, m_busy}, 32'h0);
`ifdef DEMUX_SWEEP_PARITY_EN
    check("parity", {31'b0, m_par}, {31'b0, ^e.word});
`endif
    if (accept) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("accept_valid", {31'b0, m_valid}, 32'h0);
      check("accept_retain", m_out, e.word);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_out"}, m_out, 32'h0);
    check({tag, "_sel"}, {27'b0, m_sel}, 32'h0);
    check({tag, "_busy"}, {31'b0, m_busy}, 32'h0);
    check({tag, "_valid"}, {31'b0, m_valid}, 32'h0);
  endtask

  initial begin
    vec_t vecs[6];
    int   n;
    vecs[0] = '{1'b0, 32'h55555555};
    vecs[1] = '{1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 32'h00000007};
    vecs[3] = '{1'b0, 32'h00000003};
    vecs[4] = '{1'b0, 32'hFFFFFFFF};
    vecs[5] = '{1'b1, 32'h80000001};

    tick(); tick();
    rst = 1'b0;
    cur = 1'b0; check_idle_zero("reset_a");
    cur = 1'b1; check_idle_zero("reset_b");

    foreach (vecs[i]) run_sweep(vecs[i].c, vecs[i].word, 1'b1);

    // Backpressure, with a start pulse that HOLD must ignore
    run_sweep(1'b0, 32'hA5A50F0F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      start = 1'b0;
      check("bp_valid", {31'b0, m_valid}, 32'h1);
      check("bp_out", m_out, 32'hA5A50F0F);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {31'b0, m_valid}, 32'h0);
    check("bp_retain", m_out, 32'hA5A50F0F);
    tick();
    check("bp_start_ignored", {31'b0, m_busy}, 32'h0);

    // Manual writes
    rst = 1'b1; tick(); rst = 1'b0;
    cur = 1'b0; loopback = 1'b0;
    wr_en = 1'b1; man_din = 1'b1; sel = 5'd31;
    tick();
    sel = 5'd0;
    tick();
    wr_en = 1'b0;
    check("manual_word", m_out, 32'h80000001);
`ifdef DEMUX_SWEEP_PARITY_EN
    check("manual_parity", {31'b0, m_par}, 32'h0);
`endif
    wr_en = 1'b1; man_din = 1'b0; sel = 5'd31;
    tick();
    wr_en = 1'b0;
    check("manual_clear_bit", m_out, 32'h00000001);
`ifdef DEMUX_SWEEP_PARITY_EN
    check("manual_parity1", {31'b0, m_par}, 32'h1);
`endif

    // start with coincident wr_en: the write must be dropped
    loopback = 1'b1; mux_in = 32'h0F0F0F0F;
    wr_en = 1'b1; sel = 5'd5; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    check("start_wr_drop", m_out, 32'h0);
    check("start_wr_busy", {31'b0, m_busy}, 32'h1);
    n = 0;
    while (!m_valid && n < 60) begin tick(); n++; end
    check("start_wr_word", m_out, 32'h0F0F0F0F);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset priority over start/wr_en
    rst = 1'b1; start = 1'b1; wr_en = 1'b1; sel = 5'd3;
    tick();
    rst = 1'b0; start = 1'b0; wr_en = 1'b0;
    check_idle_zero("rst_prio");

    // Reset mid-sweep at bit 17, then a clean sweep
    cur = 1'b0; loopback = 1'b1; mux_in = 32'hFFFFFFFF;
    start = 1'b1; tick(); start = 1'b0;
    repeat (17) tick();
    check("mid_sel", {27'b0, m_sel}, 32'd17);
    rst = 1'b1; tick(); rst = 1'b0;
    check_idle_zero("mid_rst");
`ifdef DEMUX_SWEEP_PARITY_EN
    check("mid_rst_parity", {31'b0, m_par}, 32'h0);
`endif
    run_sweep(1'b0, 32'h13579BDF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
